clint: RTL and testbench

Core-local interruptor for the single-hart core. Memory-mapped responder on the core's data bus that owns the 64-bit `mtime` counter, the 64-bit `mtimecmp` compare register and the `msip` software-interrupt bit. It drives the `mtip`, `msip` and `mtime` inputs of the CSR unit, so it is the source end of the machine timer/software interrupt path.

---
 rtl/clint_pkg.sv | 52 +++++
 rtl/clint_tick.sv | 21 ++
 rtl/clint.sv | 88 ++++++++
 tb/tb_clint.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, state/register types and reset values for the CLINT
package clint_pkg;

  localparam logic [15:0] clint_msip      = 16'h0000;
  localparam logic [15:0] clint_mtimecmp  = 16'h4000;
  localparam logic [15:0] clint_mtimecmph = 16'h4004;
  localparam logic [15:0] clint_mtime     = 16'hBFF8;
  localparam logic [15:0] clint_mtimeh    = 16'hBFFC;

  typedef enum logic {st_idle, st_resp} state_type;

  typedef struct packed {
    logic        instr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_type;

  typedef struct packed {
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic        mtip;
    state_type   state;
    req_type     req;
    logic        ready;
    logic [31:0] rdata;
  } clint_reg_type;

  localparam clint_reg_type init_clint_reg = '{
    mtime:    64'h0,
    mtimecmp: 64'hFFFF_FFFF_FFFF_FFFF,
    msip:     1'b0,
    mtip:     1'b0,
    state:    st_idle,
    req:      '0,
    ready:    1'b0,
    rdata:    32'h0
  };

  // Replace the bytes of a word selected by the strobes.
  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] v;
    v = old;
    for (int i = 0; i < 4; i++)
      if (wstrb[i]) v[8*i +: 8] = wdata[8*i +: 8];
    return v;
  endfunction

endpackage

// File: rtl/clint_tick.sv
// clint_tick: prescaler producing one mtime tick every RTC_DIV clocks
module clint_tick #(
  parameter int RTC_DIV = 1
) (
  input  logic reset,
  input  logic clock,
  output logic tick
);

  localparam logic [15:0] last = 16'(RTC_DIV - 1);

  logic [15:0] cnt;

  assign tick = cnt == last;

  // Count 0..RTC_DIV-1 and wrap; the wrap cycle is the tick.
  always_ff @(posedge clock)
    if (!reset) cnt <= '0;
    else        cnt <= tick ? '0 : cnt + 16'd1;

endmodule

// File: rtl/clint.sv
// clint: core-local interruptor (mtime, mtimecmp, msip); CLINT_PRESCALER_EN enables the mtime prescaler
module clint
  import clint_pkg::*;
#(
  parameter int RTC_DIV = 1
) (
  input  logic        reset,
  input  logic        clock,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mtip,
  output logic        msip,
  output logic [63:0] mtime
);

  clint_reg_type r, rin;
  logic          tick;
  logic [15:0]   a;
  logic [31:0]   rd;
  logic          unused_addr;

`ifdef CLINT_PRESCALER_EN
  clint_tick #(.RTC_DIV(RTC_DIV)) u_tick (
    .reset(reset),
    .clock(clock),
    .tick (tick)
  );
`else
  assign tick = RTC_DIV >= 1;
`endif

  assign a           = mem_addr[15:0];
  assign unused_addr = ^mem_addr[31:16];

  // Read data is taken from the registers as they stand when the request is accepted.
  assign rd = mem_instr                ? 32'h0 :
              a == clint_msip          ? {31'b0, r.msip} :
              a == clint_mtimecmp      ? r.mtimecmp[31:0] :
              a == clint_mtimecmph     ? r.mtimecmp[63:32] :
              a == clint_mtime         ? r.mtime[31:0] :
              a == clint_mtimeh        ? r.mtime[63:32] : 32'h0;

  // Next-state: timer increment, compare, bus accept in idle, write-back in resp.
  always_comb begin
    rin       = r;
    rin.mtime = r.mtime + {63'b0, tick};
    rin.mtip  = r.mtime >= r.mtimecmp;
    rin.ready = 1'b0;
    if (r.state == st_idle) begin
      if (mem_valid) begin
        rin.state = st_resp;
        rin.ready = 1'b1;
        rin.rdata = rd;
        rin.req   = '{instr: mem_instr, addr: a, wdata: mem_wdata, wstrb: mem_wstrb};
      end
    end else begin
      rin.state = st_idle;
      if (!r.req.instr) begin
        if (r.req.addr == clint_msip && r.req.wstrb[0]) rin.msip = r.req.wdata[0];
        if (r.req.addr == clint_mtimecmp)
          rin.mtimecmp[31:0] = byte_merge(r.mtimecmp[31:0], r.req.wdata, r.req.wstrb);
        if (r.req.addr == clint_mtimecmph)
          rin.mtimecmp[63:32] = byte_merge(r.mtimecmp[63:32], r.req.wdata, r.req.wstrb);
        if (r.req.addr == clint_mtime)
          rin.mtime[31:0] = byte_merge(rin.mtime[31:0], r.req.wdata, r.req.wstrb);
        if (r.req.addr == clint_mtimeh)
          rin.mtime[63:32] = byte_merge(rin.mtime[63:32], r.req.wdata, r.req.wstrb);
      end
    end
  end

  // Register bank with synchronous active-low reset.
  always_ff @(posedge clock)
    if (!reset) r <= init_clint_reg;
    else        r <= rin;

  assign mem_rdata = r.rdata;
  assign mem_ready = r.ready;
  assign mtip      = r.mtip;
  assign msip      = r.msip;
  assign mtime     = r.mtime;

endmodule

// File: tb/tb_clint.sv
// tb_clint: directed and randomized checks of clint against a timeline model of mtime/mtimecmp/msip
module tb_clint;

`ifdef CLINT_PRESCALER_EN
  localparam int RTC = 4;
`else
  localparam int RTC = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mtip;
  logic        msip;
  logic [63:0] mtime;

  clint #(.RTC_DIV(RTC)) dut (
    .reset    (reset),
    .clock    (clock),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mtip     (mtip),
    .msip     (msip),
    .mtime    (mtime)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model: mtime is a linear function of the cycle count since its last write.
  int unsigned cyc = 0;
  int unsigned mt_cyc = 0;
  logic [63:0] mt_base = '0;
  logic [63:0] cmp = '1;
  logic        m_msip = 1'b0;
  logic [63:0] prev_mt = '0;
  logic [63:0] prev_cmp = '1;

  // Snapshot the model just before each edge so the registered compare can be predicted.
  always @(posedge clock) begin
    prev_mt  = mt_base + 64'(cyc - mt_cyc);
    prev_cmp = cmp;
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] now_mt();
    return mt_base + 64'(cyc - mt_cyc);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = o;
    for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
    return v;
  endfunction

  function automatic logic [31:0] ref_read(input logic [15:0] a, input logic instr);
    logic [63:0] t;
    t = now_mt();
    if (instr) return 32'h0;
    case (a)
      16'h0000: return {31'b0, m_msip};
      16'h4000: return cmp[31:0];
      16'h4004: return cmp[63:32];
      16'hBFF8: return t[31:0];
      16'hBFFC: return t[63:32];
      default:  return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "/mtime"}, mtime, now_mt());
    chk({tag, "/msip"}, {63'b0, msip}, {63'b0, m_msip});
    chk({tag, "/mtip"}, {63'b0, mtip}, {63'b0, prev_mt >= prev_cmp});
  endtask

  task automatic model_reset();
    mt_base = '0;
    mt_cyc  = cyc;
    cmp     = '1;
    m_msip  = 1'b0;
  endtask

  // One complete request: accept edge, response cycle, landing edge.
  task automatic xfer(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic instr, output logic [31:0] rd);
    logic [31:0] er;
    logic [63:0] v;
    er        = ref_read(a, instr);
    mem_valid = 1'b1;
    mem_addr  = {16'($urandom), a};
    mem_wdata = d;
    mem_wstrb = s;
    mem_instr = instr;
    step(1);
    rd = mem_rdata;
    chk("ready", {63'b0, mem_ready}, 64'd1);
    chk("rdata", {32'b0, mem_rdata}, {32'b0, er});
    check_state("resp");
    mem_valid = 1'b0;
    mem_wstrb = '0;
    mem_instr = 1'b0;
    step(1);
    if (!instr) begin
      case (a)
        16'h0000: if (s[0]) m_msip = d[0];
        16'h4000: cmp[31:0]  = merge(cmp[31:0], d, s);
        16'h4004: cmp[63:32] = merge(cmp[63:32], d, s);
        16'hBFF8: begin v = now_mt(); v[31:0]  = merge(v[31:0], d, s);  mt_base = v; mt_cyc = cyc; end
        16'hBFFC: begin v = now_mt(); v[63:32] = merge(v[63:32], d, s); mt_base = v; mt_cyc = cyc; end
        default: ;
      endcase
    end
    chk("ready_drop", {63'b0, mem_ready}, 64'd0);
    check_state("land");
  endtask

  initial begin
    logic [31:0] rd;
    logic [15:0] a;
    logic [3:0]  s;
    logic        ins;
    int          k;
    reset = 1'b0;
    step(3);
    model_reset();
    chk("rst_mtime", mtime, 64'd0);
    chk("rst_mtip", {63'b0, mtip}, 64'd0);
    chk("rst_msip", {63'b0, msip}, 64'd0);
    chk("rst_ready", {63'b0, mem_ready}, 64'd0);
    chk("rst_rdata", {32'b0, mem_rdata}, 64'd0);
    reset = 1'b1;
`ifdef CLINT_PRESCALER_EN
    for (int i = 1; i <= 16; i++) begin
      step(1);
      chk("presc_mtime", mtime, 64'(i / 4));
    end
`else
    step(1);
    chk("run_mtime1", mtime, 64'd1);
    step(1);
    chk("run_mtime2", mtime, 64'd2);
    xfer(16'h4004, 32'h0, 4'h0, 1'b0, rd);
    chk("cmph_reset", {32'b0, rd}, 64'hFFFF_FFFF);

    xfer(16'h0000, 32'h1, 4'hF, 1'b0, rd);
    chk("msip_set", {63'b0, msip}, 64'd1);
    xfer(16'h0000, 32'h0, 4'hE, 1'b0, rd);
    chk("msip_keep", {63'b0, msip}, 64'd1);

    xfer(16'h4004, 32'h0, 4'hF, 1'b0, rd);
    xfer(16'h4000, 32'h20, 4'hF, 1'b0, rd);
    for (int n = 0; n < 64 && mtime !== 64'h20; n++) step(1);
    chk("reach_20", mtime, 64'h20);
    chk("mtip_pre", {63'b0, mtip}, 64'd0);
    step(1);
    chk("mtip_fire", {63'b0, mtip}, 64'd1);
    xfer(16'h4000, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
    chk("mtip_hold", {63'b0, mtip}, 64'd1);
    step(1);
    chk("mtip_clear", {63'b0, mtip}, 64'd0);

    xfer(16'hBFFC, 32'h0, 4'hF, 1'b0, rd);
    xfer(16'hBFF8, 32'hFFFF_FFFE, 4'hF, 1'b0, rd);
    chk("mtime_load", mtime, 64'hFFFF_FFFE);
    step(2);
    chk("mtime_carry", mtime, 64'h1_0000_0000);
    xfer(16'hBFF8, 32'hAB, 4'h1, 1'b0, rd);
    chk("mtime_byte", mtime, 64'h1_0000_00AB);

    mem_valid = 1'b1;
    mem_addr  = 32'hA5A5_1234;
    mem_wstrb = 4'h0;
    mem_instr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) begin
        mem_instr = 1'b1;
        mem_addr  = 32'h0000_BFF8;
        mem_wdata = 32'h1234_5678;
        mem_wstrb = 4'hF;
      end
      step(1);
      chk("b2b_ready", {63'b0, mem_ready}, {63'b0, i % 2 == 0});
      if (i % 2 == 0) chk("b2b_rdata", {32'b0, mem_rdata}, 64'd0);
    end
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_wstrb = 4'h0;
    check_state("b2b_end");

    mem_valid = 1'b1;
    mem_addr  = 32'h0000_4000;
    mem_wdata = 32'h55;
    mem_wstrb = 4'hF;
    step(1);
    chk("rr_ready", {63'b0, mem_ready}, 64'd1);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    reset = 1'b0;
    step(1);
    model_reset();
    chk("rr_drop", {63'b0, mem_ready}, 64'd0);
    chk("rr_mtime", mtime, 64'd0);
    chk("rr_msip", {63'b0, msip}, 64'd0);
    reset = 1'b1;
    xfer(16'h4000, 32'h0, 4'h0, 1'b0, rd);
    chk("rr_cmp", {32'b0, rd}, 64'hFFFF_FFFF);

    for (int t = 0; t < 40; t++) begin
      k   = $urandom_range(0, 5);
      a   = k == 0 ? 16'h0000 : k == 1 ? 16'h4000 : k == 2 ? 16'h4004 :
            k == 3 ? 16'hBFF8 : k == 4 ? 16'hBFFC : 16'($urandom);
      s   = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom);
      ins = $urandom_range(0, 7) == 0;
      xfer(a, $urandom, s, ins, rd);
      if ($urandom_range(0, 3) == 0) begin
        step($urandom_range(1, 5));
        check_state("idle");
      end
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
